// File: rtl/cenn_baw_scanout.sv
// Scan-out sequencer: drains NUM_PE settled CeNN outputs, binarizes them against a per-frame
// threshold and streams 8-bit pixels over valid/ready. Define CENN_GRAY_OUT_EN for grayscale output.
module cenn_baw_scanout #(
    parameter int WIDTH_FIXED = 15,
    parameter int WIDTH_BAW   = 8,
    parameter int NUM_PE      = 10,
    parameter int SEL_W       = $clog2(NUM_PE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   press_DOWN,
    input  logic                   press_UP,
    output logic [SEL_W-1:0]       pe_sel,
    input  logic [WIDTH_FIXED-1:0] pe_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [WIDTH_BAW-1:0]   pix_data,
    output logic                   pix_last,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             led
);

    localparam logic [SEL_W-1:0]     LAST_IDX  = SEL_W'(NUM_PE - 1);
    localparam logic [WIDTH_BAW-1:0] PIX_WHITE = '1;
    localparam logic [4:0]           LEVEL_MID = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [4:0]           level_q, level_d;
    logic [4:0]           led_q, led_d;
    logic                 pix_valid_q, pix_valid_d;
    logic                 pix_last_q, pix_last_d;
    logic                 done_q, done_d;
    logic [WIDTH_BAW-1:0] pix_value;

    // Threshold level: saturating up/down, simultaneous presses cancel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        level_d = level_q;
        led_d   = level_q;
        if (press_UP && !press_DOWN && level_q != 5'd31) begin
            level_d = level_q + 5'd1;
        end else if (press_DOWN && !press_UP && level_q != 5'd0) begin
            level_d = level_q - 5'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                pix_valid_d = 1'b1;
                pix_last_d  = (idx_q == LAST_IDX);
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            level_q     <= LEVEL_MID;
            led_q       <= LEVEL_MID;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            level_q     <= level_d;
            led_q       <= led_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            done_q      <= done_d;
        end
    end

`ifndef CENN_GRAY_OUT_EN
    logic signed [5:0]             level_off;
    logic signed [WIDTH_FIXED-1:0] thr_cur;
    logic signed [WIDTH_FIXED-1:0] thr_frame_q, thr_frame_d;

    // thr = (level - 16) * 32, sign-extended to the PE fixed-point width.
    assign level_off = $signed({1'b0, level_q}) - 6'sd16;
    assign thr_cur   = {{(WIDTH_FIXED - 11){level_off[5]}}, level_off, 5'b00000};

    always_comb begin
        thr_frame_d = thr_frame_q;
        if (state_q == S_IDLE && start) begin
            thr_frame_d = thr_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_frame_q <= '0;
        end else begin
            thr_frame_q <= thr_frame_d;
        end
    end

    // CeNN convention: positive (above threshold) is black, equality stays white.
    assign pix_value = ($signed(pe_data) > thr_frame_q) ? '0 : PIX_WHITE;
`else
    localparam logic signed [WIDTH_FIXED-1:0] ONE_POS = 512;
    localparam logic signed [WIDTH_FIXED-1:0] ONE_NEG = -512;

    logic signed [WIDTH_FIXED-1:0] clamped;
    int                            gray_lvl;

    always_comb begin
        clamped = $signed(pe_data);
        if ($signed(pe_data) > ONE_POS) begin
            clamped = ONE_POS;
        end else if ($signed(pe_data) < ONE_NEG) begin
            clamped = ONE_NEG;
        end
        gray_lvl = (int'(clamped) + 512) >>> 2;
        if (gray_lvl > 255) begin
            gray_lvl = 255;
        end
        pix_value = WIDTH_BAW'(255 - gray_lvl);
    end
`endif

    // pe_data is a registered mux output held by pe_sel for all of EMIT, so the pixel is stable.
    assign pe_sel    = idx_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_valid_q ? pix_value : '0;
    assign pix_last  = pix_last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign led       = led_q;

endmodule
